itof_issue_queue: RTL and testbench
===================================

Name: itof_issue_queue

Overview:
- Streaming front/back end around the single-cycle integer-to-float converter core.
- Accepts tagged 32-bit integer operands from FPU dispatch on a valid/ready interface and buffers them in a small FIFO.
- Issues at most one operand per cycle to the converter core, captures the core's registered result one cycle later, and holds results in a result buffer until writeback accepts them.
- Writeback backpressure never drops a converter result.

Parameters:
DEPTH, 4, operand FIFO entries; power of two, at least 2
RB_DEPTH, 2, result buffer entries; at least 2
TAG_W, 5, width of destination-register tag carried with each operation

Ports:
clk  in  1  clock; all state changes on posedge
rstn  in  1  synchronous active-low reset, sampled on posedge clk
flush  in  1  synchronous discard of all queued, in-flight and buffered operations
in_valid  in  1  dispatch offers an operand
in_ready  out  1  queue can accept; asserted when FIFO not full, flush low and rstn high
in_data  in  32  two's-complement integer operand
in_tag  in  TAG_W  destination tag
itof_x  out  32  operand to converter core; equals FIFO head data when issuing, else 0
itof_y  in  32  converter core result; valid the cycle after the issue cycle
out_valid  out  1  result buffer head valid
out_ready  in  1  writeback accepts
out_data  out  32  IEEE-754 single result
out_tag  out  TAG_W  tag matching out_data
busy  out  1  high if any FIFO entry, in-flight op or buffered result exists

Behaviour:
- Reset (rstn low at posedge):
  - FIFO, in-flight flag and result buffer are emptied; all pointers are 0.
  - out_valid=0, out_data=0, out_tag=0, busy=0, itof_x=0.
  - in_ready is 0 while rstn is low.
  - Reset mid-operation discards everything.
- Accept: in_fire = in_valid & in_ready. On in_fire the entry is written at the FIFO tail at that edge.
- FIFO full: in_ready=0 and no write occurs.
- Simultaneous accept and issue on a full FIFO: not allowed, because in_ready is based on the registered full flag only.
- Issue condition, evaluated in the same cycle:
  - FIFO non-empty, flush low, and
  - (rb_count + inflight − out_fire) < RB_DEPTH, where out_fire = out_valid & out_ready.
- On issue:
  - itof_x = head data.
  - The FIFO pops at the edge.
  - inflight<=1 and inflight_tag<=head tag.
  - If there is no issue that cycle, inflight<=0.
- Capture: in any cycle with inflight=1, {itof_y, inflight_tag} is written into the result buffer tail at the edge. Capture and out_fire in the same cycle are allowed; the count stays the same.
- Output: out_valid=(rb_count!=0). out_data and out_tag come from the buffer head. The head advances on out_fire.
- Ordering: results leave strictly in acceptance order.
- Latency: accept at edge E0 → issue in cycle 1 → core registers at E1 → capture at E2 → out_valid in cycle 3. Minimum latency is 3 cycles.
- Throughput: with out_ready held high, one result per cycle sustained.
- Empty FIFO: no issue, itof_x=0.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full/empty are determined from a separate occupancy count.
- Flush (flush=1 at posedge):
  - FIFO, inflight and result buffer are cleared.
  - in_ready=0 and no issue occurs that cycle.
  - out_valid is 0 in the following cycle.
  - A core result arriving in the cycle after the flush edge is ignored, because inflight was cleared.
  - If in_valid is asserted during flush, it is not accepted.
- Flush and reset together: reset wins, with identical effect.
- Converter semantics, as guaranteed by the core and checked end-to-end:
  - Magnitude is truncated, not rounded.
  - 0 maps to 0x00000000.
  - 0x80000000 maps to 0xCF000000.

Test Plan:
- Reset, then single op in_data=1, tag=3 at E0 → out_valid first in cycle 3, out_data=0x3F800000, out_tag=3; busy falls after out_fire.
- Back-to-back stream 7, −1, 0, 0x80000000 with out_ready=1 → one result per cycle in order: 0x40E00000, 0xBF800000, 0x00000000, 0xCF000000, with matching tags.
- out_ready=0 while 6 ops are offered → exactly DEPTH+RB_DEPTH=6 accepted; in_ready low after FIFO fill; no result lost. Release out_ready → all 6 drain in order.
- Truncation: 0x01000001 → 0x4B800000; 0xFEFFFFFF (−16777217) → 0xCB800000.
- Flush with 2 queued, 1 in-flight and 1 buffered → next cycle out_valid=0, busy=0; the later core output is never presented. A new op of 2 after flush → 0x40000000 with 3-cycle latency.
- rstn low for 1 cycle mid-stream with out_ready toggling → all outputs return to 0. FIFO pointers wrap correctly over 3×DEPTH subsequent ops, compared against a scoreboard.

Source files
------------

// File: rtl/itof_issue_queue.sv
// itof_issue_queue: streaming wrapper around a single-cycle integer-to-float
// core. Operands are buffered in a small FIFO and issued one per cycle. The
// core's registered result is captured one cycle after issue and held in a
// result buffer until writeback takes it. An operand is only issued when the
// result buffer is guaranteed to have room for its result, so a result is
// never dropped.
module itof_issue_queue #(
  parameter int DEPTH    = 4,
  parameter int RB_DEPTH = 2,
  parameter int TAG_W    = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      itof_x,
  input  logic [31:0]      itof_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int RPW = (RB_DEPTH > 1) ? $clog2(RB_DEPTH) : 1;
  localparam int RCW = $clog2(RB_DEPTH + 1);

  localparam logic [CW-1:0]  FQ_FULL_C = CW'(DEPTH);
  localparam logic [RCW:0]   RB_LIM_C  = (RCW + 1)'(RB_DEPTH);
  localparam logic [RPW-1:0] RB_LAST_C = RPW'(RB_DEPTH - 1);

  // Operand FIFO storage and control
  logic [31:0]      fq_data_q [DEPTH];
  logic [TAG_W-1:0] fq_tag_q  [DEPTH];
  logic [PW-1:0]    fq_wr_q, fq_wr_d;
  logic [PW-1:0]    fq_rd_q, fq_rd_d;
  logic [CW-1:0]    fq_cnt_q, fq_cnt_d;

  // In-flight operation tracking (one operation inside the core at most)
  logic             inflight_q, inflight_d;
  logic [TAG_W-1:0] inflight_tag_q, inflight_tag_d;

  // Result buffer storage and control
  logic [31:0]      rb_data_q [RB_DEPTH];
  logic [TAG_W-1:0] rb_tag_q  [RB_DEPTH];
  logic [RPW-1:0]   rb_wr_q, rb_wr_d;
  logic [RPW-1:0]   rb_rd_q, rb_rd_d;
  logic [RCW-1:0]   rb_cnt_q, rb_cnt_d;

  logic             fq_full_s;
  logic             fq_empty_s;
  logic             in_fire_s;
  logic             out_fire_s;
  logic             issue_s;
  logic             capture_s;
  logic [RCW:0]     rb_occ_s;

  assign fq_full_s  = (fq_cnt_q == FQ_FULL_C);
  assign fq_empty_s = (fq_cnt_q == {CW{1'b0}});
  // Acceptance depends only on registered occupancy, never on this cycle's issue.
  assign in_ready   = rstn & ~flush & ~fq_full_s;
  assign in_fire_s  = in_valid & in_ready;

  assign out_valid  = (rb_cnt_q != {RCW{1'b0}});
  assign out_fire_s = out_valid & out_ready;

  // Result slots that will be occupied after this edge if nothing new issues.
  // out_fire implies rb_cnt_q >= 1, so the subtraction cannot underflow.
  assign rb_occ_s   = {1'b0, rb_cnt_q} + {{RCW{1'b0}}, inflight_q}
                    - {{RCW{1'b0}}, out_fire_s};
  assign issue_s    = rstn & ~flush & ~fq_empty_s & (rb_occ_s < RB_LIM_C);
  assign capture_s  = rstn & ~flush & inflight_q;

  assign itof_x     = issue_s ? fq_data_q[fq_rd_q] : 32'd0;
  assign out_data   = out_valid ? rb_data_q[rb_rd_q] : 32'd0;
  assign out_tag    = out_valid ? rb_tag_q[rb_rd_q] : {TAG_W{1'b0}};
  assign busy       = ~fq_empty_s | inflight_q | out_valid;

  // Next-state computation for pointers, counts and in-flight tracking.
  always_comb begin
    fq_wr_d        = fq_wr_q;
    fq_rd_d        = fq_rd_q;
    fq_cnt_d       = fq_cnt_q;
    inflight_d     = inflight_q;
    inflight_tag_d = inflight_tag_q;
    rb_wr_d        = rb_wr_q;
    rb_rd_d        = rb_rd_q;
    rb_cnt_d       = rb_cnt_q;
    if (flush) begin
      fq_wr_d        = {PW{1'b0}};
      fq_rd_d        = {PW{1'b0}};
      fq_cnt_d       = {CW{1'b0}};
      inflight_d     = 1'b0;
      inflight_tag_d = {TAG_W{1'b0}};
      rb_wr_d        = {RPW{1'b0}};
      rb_rd_d        = {RPW{1'b0}};
      rb_cnt_d       = {RCW{1'b0}};
    end else begin
      if (in_fire_s) begin
        fq_wr_d = fq_wr_q + PW'(1'b1);
      end else begin
        fq_wr_d = fq_wr_q;
      end
      if (issue_s) begin
        fq_rd_d        = fq_rd_q + PW'(1'b1);
        inflight_d     = 1'b1;
        inflight_tag_d = fq_tag_q[fq_rd_q];
      end else begin
        fq_rd_d        = fq_rd_q;
        inflight_d     = 1'b0;
        inflight_tag_d = inflight_tag_q;
      end
      fq_cnt_d = fq_cnt_q + {{(CW-1){1'b0}}, in_fire_s}
                          - {{(CW-1){1'b0}}, issue_s};
      if (capture_s) begin
        rb_wr_d = (rb_wr_q == RB_LAST_C) ? {RPW{1'b0}} : rb_wr_q + RPW'(1'b1);
      end else begin
        rb_wr_d = rb_wr_q;
      end
      if (out_fire_s) begin
        rb_rd_d = (rb_rd_q == RB_LAST_C) ? {RPW{1'b0}} : rb_rd_q + RPW'(1'b1);
      end else begin
        rb_rd_d = rb_rd_q;
      end
      rb_cnt_d = rb_cnt_q + {{(RCW-1){1'b0}}, capture_s}
                          - {{(RCW-1){1'b0}}, out_fire_s};
    end
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      fq_wr_q        <= {PW{1'b0}};
      fq_rd_q        <= {PW{1'b0}};
      fq_cnt_q       <= {CW{1'b0}};
      inflight_q     <= 1'b0;
      inflight_tag_q <= {TAG_W{1'b0}};
      rb_wr_q        <= {RPW{1'b0}};
      rb_rd_q        <= {RPW{1'b0}};
      rb_cnt_q       <= {RCW{1'b0}};
    end else begin
      fq_wr_q        <= fq_wr_d;
      fq_rd_q        <= fq_rd_d;
      fq_cnt_q       <= fq_cnt_d;
      inflight_q     <= inflight_d;
      inflight_tag_q <= inflight_tag_d;
      rb_wr_q        <= rb_wr_d;
      rb_rd_q        <= rb_rd_d;
      rb_cnt_q       <= rb_cnt_d;
    end
  end

  // Operand FIFO storage; contents are only observed through valid entries.
  always_ff @(posedge clk) begin
    if (in_fire_s) begin
      fq_data_q[fq_wr_q] <= in_data;
      fq_tag_q[fq_wr_q]  <= in_tag;
    end
  end

  // Result buffer storage; the core result is paired with the in-flight tag.
  always_ff @(posedge clk) begin
    if (capture_s) begin
      rb_data_q[rb_wr_q] <= itof_y;
      rb_tag_q[rb_wr_q]  <= inflight_tag_q;
    end
  end

endmodule

// File: tb/tb_itof_issue_queue.sv
// Bench for itof_issue_queue: directed operands with hand-computed float
// results, a scoreboard queue filled on acceptance and a monitor that pops
// and compares whenever writeback takes a result. A behavioural registered
// converter stands in for the core.
module tb_itof_issue_queue;

  logic        clk = 1'b0;
  logic        rstn, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] in_data, itof_x, out_data;
  logic [31:0] itof_y = 32'd0;
  logic [4:0]  in_tag, out_tag;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          pop_cnt = 0;
  logic [36:0] exp_q[$];
  int          pop_cyc_q[$];
  bit          tog_en = 1'b0;
  bit          rdy_lvl = 1'b0;

  itof_issue_queue #(.DEPTH(4), .RB_DEPTH(2), .TAG_W(5)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
    .itof_x(itof_x), .itof_y(itof_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Truncating int-to-float conversion used by the stand-in core.
  function automatic logic [31:0] cvt(input logic [31:0] x);
    logic        s;
    logic [31:0] m, sh;
    int          p;
    if (x == 32'd0) return 32'd0;
    s = x[31];
    m = s ? (~x + 32'd1) : x;
    p = 31;
    while (!m[p]) p--;
    sh = m << (31 - p);
    return {s, 8'(127 + p), sh[30:8]};
  endfunction

  always @(posedge clk) itof_y <= cvt(itof_x);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // out_ready driver: either a held level or a toggle each cycle.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      out_ready = tog_en ? ~out_ready : rdy_lvl;
    end
  end

  // Monitor: compare each result taken by writeback against the scoreboard.
  always @(negedge clk) begin
    logic [36:0] e;
    if (rstn && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_out: got data=%h tag=%0d expected no output", out_data, out_tag);
      end else if (out_ready) begin
        e = exp_q.pop_front();
        chk("out_data", out_data, e[31:0]);
        chk("out_tag", 32'(out_tag), 32'(e[36:32]));
        pop_cyc_q.push_back(cyc);
        pop_cnt++;
      end
    end
  end

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  // Offer one operand; must be called at posedge+1. Returns at posedge+1.
  task automatic offer(input logic [31:0] d, input logic [4:0] t, input logic [31:0] e,
                       input int max_wait, output bit acc, output int w);
    in_valid = 1'b1;
    in_data  = d;
    in_tag   = t;
    acc = 1'b0;
    w = 0;
    for (int i = 0; i < max_wait && !acc; i++) begin
      @(negedge clk);
      w++;
      if (in_ready) begin
        exp_q.push_back({t, e});
        acc = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic [4:0] t, input logic [31:0] e);
    bit acc;
    int w;
    offer(d, t, e, 20, acc, w);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accept expected accept of %h", d);
    end
  endtask

  // Single op with out_ready high: check issue operand, latency and busy.
  task automatic lat_op(input logic [31:0] d, input logic [4:0] t, input logic [31:0] e);
    int lat;
    bit seen;
    send(d, t, e);
    lat = 0;
    seen = 1'b0;
    for (int i = 1; i <= 8 && !seen; i++) begin
      @(negedge clk);
      if (i == 1) chk("issue_x", itof_x, d);
      if (i == 2) chk("idle_x", itof_x, 32'd0);
      if (out_valid) begin
        seen = 1'b1;
        lat = i;
        chk("busy_with_result", 32'(busy), 32'd1);
      end
    end
    chk("latency", 32'(lat), 32'd3);
    @(negedge clk);
    chk("busy_after_fire", 32'(busy), 32'd0);
    chk("valid_after_fire", 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] vin[12];
    logic [31:0] vexp[12];
    bit acc;
    int w, stalls, acc_cnt, p0;

    vin  = '{32'd1, 32'hFFFFFFFE, 32'd3, 32'd100, 32'd255, 32'd256,
             32'd1000, 32'hFFFFFC18, 32'h7FFFFFFF, 32'd65535, 32'h00FFFFFF, 32'hFFFFFFF9};
    vexp = '{32'h3F800000, 32'hC0000000, 32'h40400000, 32'h42C80000, 32'h437F0000, 32'h43800000,
             32'h447A0000, 32'hC47A0000, 32'h4EFFFFFF, 32'h477FFF00, 32'h4B7FFFFF, 32'hC0E00000};

    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 32'd0; in_tag = 5'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    align();
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_itof_x", itof_x, 32'd0);
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // Single op, latency and busy
    rdy_lvl = 1'b1;
    align();
    lat_op(32'd1, 5'd3, 32'h3F800000);

    // Back-to-back stream, one result per cycle
    align();
    pop_cyc_q.delete();
    stalls = 0;
    offer(32'd7,         5'd4, 32'h40E00000, 20, acc, w); stalls += w - 1;
    offer(32'hFFFFFFFF,  5'd5, 32'hBF800000, 20, acc, w); stalls += w - 1;
    offer(32'd0,         5'd6, 32'h00000000, 20, acc, w); stalls += w - 1;
    offer(32'h80000000,  5'd7, 32'hCF000000, 20, acc, w); stalls += w - 1;
    repeat (6) @(negedge clk);
    chk("stream_stalls", 32'(stalls), 32'd0);
    chk("stream_pops", 32'(pop_cyc_q.size()), 32'd4);
    if (pop_cyc_q.size() == 4) chk("stream_span", 32'(pop_cyc_q[3] - pop_cyc_q[0]), 32'd3);

    // Backpressure: exactly DEPTH+RB_DEPTH accepted, nothing lost
    rdy_lvl = 1'b0;
    align();
    acc_cnt = 0;
    for (int k = 0; k < 7; k++) begin
      offer(32'(10 + k), 5'(10 + k), cvt(32'(10 + k)), 8, acc, w);
      if (acc) acc_cnt++;
    end
    chk("bp_accepted", 32'(acc_cnt), 32'd6);
    @(negedge clk);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    p0 = pop_cnt;
    align();
    rdy_lvl = 1'b1;
    repeat (14) @(negedge clk);
    chk("bp_drained", 32'(pop_cnt - p0), 32'd6);
    chk("bp_sb_empty", 32'(exp_q.size()), 32'd0);

    // Truncation of magnitude
    align();
    send(32'h01000001, 5'd8, 32'h4B800000);
    send(32'hFEFFFFFF, 5'd9, 32'hCB800000);
    repeat (6) @(negedge clk);
    chk("trunc_sb_empty", 32'(exp_q.size()), 32'd0);

    // Flush with queued, in-flight and buffered work
    rdy_lvl = 1'b0;
    align();
    send(32'd20, 5'd20, 32'h41A00000);
    send(32'd21, 5'd21, 32'h41A80000);
    send(32'd22, 5'd22, 32'h41B00000);
    send(32'd23, 5'd23, 32'h41B80000);
    send(32'd24, 5'd24, 32'h41C00000);
    repeat (4) @(posedge clk);
    #1;
    rdy_lvl = 1'b1;
    @(posedge clk);
    #1;
    rdy_lvl = 1'b0;
    flush = 1'b1;
    in_valid = 1'b1;
    in_data = 32'd99;
    in_tag = 5'd31;
    @(negedge clk);
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    chk("flush_itof_x", itof_x, 32'd0);
    chk("flush_busy_before", 32'(busy), 32'd1);
    @(posedge clk);
    exp_q.delete();
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_busy", 32'(busy), 32'd0);
    rdy_lvl = 1'b1;
    repeat (5) @(negedge clk);
    chk("flush_quiet_busy", 32'(busy), 32'd0);
    align();
    lat_op(32'd2, 5'd2, 32'h40000000);

    // Reset mid-stream with toggling writeback
    align();
    tog_en = 1'b1;
    send(32'd5, 5'd1, 32'h40A00000);
    send(32'd6, 5'd2, 32'h40C00000);
    send(32'd7, 5'd3, 32'h40E00000);
    rstn = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    exp_q.delete();
    #1;
    rstn = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_data", out_data, 32'd0);
    chk("mid_rst_out_tag", 32'(out_tag), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_itof_x", itof_x, 32'd0);

    // 3*DEPTH ops to wrap the pointers, checked by the scoreboard
    align();
    p0 = pop_cnt;
    for (int k = 0; k < 12; k++) send(vin[k], 5'(k + 1), vexp[k]);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    chk("wrap_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("wrap_pops", 32'(pop_cnt - p0), 32'd12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
